// File: rtl/quadrature_angle_tracker.sv
// Angle tracker for a two-channel hall sensor pair.
// The inputs are synchronised and deglitched, then every quadrature edge is
// decoded as a +/-1 step into a wrapping angle count. Illegal double-bit
// transitions set a sticky fault flag.
// Optional feature: define QAT_VELOCITY_EN to enable windowed velocity measurement.
module quadrature_angle_tracker #(
  parameter int unsigned ANGLE_W        = 12,
  parameter int unsigned COUNTS_PER_REV = 4024,
  parameter int unsigned FILTER_LEN     = 3,
  parameter int unsigned VEL_WINDOW     = 1000,
  parameter int unsigned VEL_W          = 16
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               hall_1,
  input  logic               hall_2,
  input  logic               monitor,
  input  logic               zero,
  input  logic               fault_clr,
  output logic [ANGLE_W-1:0] angle,
  output logic               dir,
  output logic               step,
  output logic               fault,
  output logic [VEL_W-1:0]   velocity,
  output logic               vel_valid
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(FILTER_LEN - 1);
  localparam logic [ANGLE_W-1:0] ANGLE_LAST = ANGLE_W'(COUNTS_PER_REV - 1);

  // Bit 1 carries hall_1, bit 0 carries hall_2.
  logic [1:0]       meta;
  logic [1:0]       sync;
  logic [1:0]       vld;
  logic [1:0]       filt;
  logic [CNT_W-1:0] cnt [2];
  logic [1:0]       prev;
  logic             primed;
  logic             settled;
  logic             inc;
  logic             dec;
  logic             bad;

  // Clockwise successor: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] cw_next(input logic [1:0] p);
    case (p)
      2'b00:   cw_next = 2'b10;
      2'b10:   cw_next = 2'b11;
      2'b11:   cw_next = 2'b01;
      default: cw_next = 2'b00;
    endcase
  endfunction

  // Two-flop synchronisers; vld marks when the sync stage holds real samples.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      meta <= 2'b00;
      sync <= 2'b00;
      vld  <= 2'b00;
    end else begin
      meta <= {hall_1, hall_2};
      sync <= meta;
      vld  <= {vld[0], 1'b1};
    end
  end

  // Per-channel filter: accept a new level after FILTER_LEN consecutive samples.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      filt <= 2'b00;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (vld[1] && (sync[i] != filt[i])) begin
          if (cnt[i] == CNT_LAST) begin
            filt[i] <= sync[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Filters are settled once real samples have arrived and nothing is pending.
  assign settled = vld[1] && (sync == filt) && (cnt[0] == '0) && (cnt[1] == '0);

  // Quadrature decode of the filtered phase against the previous phase.
  always_comb begin
    inc = 1'b0;
    dec = 1'b0;
    bad = 1'b0;
    if (primed) begin
      if (filt == cw_next(prev)) begin
        inc = 1'b1;
      end else if (prev == cw_next(filt)) begin
        dec = 1'b1;
      end else if (filt != prev) begin
        bad = 1'b1;
      end
    end
  end

  // Phase history and priming; prev simply tracks filt so priming loads it for free.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      prev   <= 2'b00;
      primed <= 1'b0;
    end else begin
      prev   <= filt;
      primed <= primed | settled;
    end
  end

  // Registered step/direction/fault outputs and the wrapping angle count.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      angle <= '0;
      dir   <= 1'b1;
      step  <= 1'b0;
      fault <= 1'b0;
    end else begin
      step <= inc | dec;
      if (inc) begin
        dir <= 1'b1;
      end else if (dec) begin
        dir <= 1'b0;
      end
      if (bad) begin
        fault <= 1'b1;
      end else if (fault_clr) begin
        fault <= 1'b0;
      end
      if (zero) begin
        angle <= '0;
      end else if (monitor && inc) begin
        angle <= (angle == ANGLE_LAST) ? '0 : angle + ANGLE_W'(1);
      end else if (monitor && dec) begin
        angle <= (angle == '0) ? ANGLE_LAST : angle - ANGLE_W'(1);
      end
    end
  end

`ifdef QAT_VELOCITY_EN
  localparam int unsigned WIN_W = (VEL_WINDOW > 1) ? $clog2(VEL_WINDOW) : 1;
  localparam logic [WIN_W-1:0]        WIN_LAST = WIN_W'(VEL_WINDOW - 1);
  localparam logic signed [VEL_W-1:0] VEL_MAX  = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W-1:0] VEL_MIN  = -VEL_MAX;

  logic [WIN_W-1:0]        win_cnt;
  logic signed [VEL_W-1:0] acc;
  logic signed [VEL_W-1:0] acc_nxt;

  // Saturating signed step accumulation, including this cycle's step.
  always_comb begin
    acc_nxt = acc;
    if (inc && (acc != VEL_MAX)) begin
      acc_nxt = acc + VEL_W'(1);
    end else if (dec && (acc != VEL_MIN)) begin
      acc_nxt = acc - VEL_W'(1);
    end
  end

  // Window counter; publishes the accumulated count on the last window cycle.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      win_cnt   <= '0;
      acc       <= '0;
      velocity  <= '0;
      vel_valid <= 1'b0;
    end else if (win_cnt == WIN_LAST) begin
      win_cnt   <= '0;
      acc       <= '0;
      velocity  <= acc_nxt;
      vel_valid <= 1'b1;
    end else begin
      win_cnt   <= win_cnt + WIN_W'(1);
      acc       <= acc_nxt;
      vel_valid <= 1'b0;
    end
  end
`else
  assign velocity  = '0;
  assign vel_valid = 1'b0;
`endif

endmodule

// File: tb/tb_quadrature_angle_tracker.sv
// Directed self-checking bench for quadrature_angle_tracker.
// Velocity checks are compiled in when QAT_VELOCITY_EN is defined.
module tb_quadrature_angle_tracker;

  logic        CLK = 1'b0;
  logic        reset;
  logic        hall_1, hall_2;
  logic        monitor, zero, fault_clr;
  logic [11:0] angle;
  logic        dir, step, fault;
  logic [15:0] velocity;
  logic        vel_valid;

  int n_checks = 0;
  int n_pass   = 0;
  int step_cnt = 0;
  int vv_cnt   = 0;
  logic [15:0] last_vel = '0;
  logic [1:0]  ph;
  int base;

  quadrature_angle_tracker dut (
    .CLK       (CLK),
    .reset     (reset),
    .hall_1    (hall_1),
    .hall_2    (hall_2),
    .monitor   (monitor),
    .zero      (zero),
    .fault_clr (fault_clr),
    .angle     (angle),
    .dir       (dir),
    .step      (step),
    .fault     (fault),
    .velocity  (velocity),
    .vel_valid (vel_valid)
  );

  always #5 CLK = ~CLK;

  // Count step pulses and capture each published velocity.
  always @(posedge CLK) begin
    if (step) step_cnt <= step_cnt + 1;
    if (vel_valid) begin
      vv_cnt   <= vv_cnt + 1;
      last_vel <= velocity;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [1:0] cw_of(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] ccw_of(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic drive_phase();
    hall_1 = ph[1];
    hall_2 = ph[0];
  endtask

  // n sensor steps in one direction, gap clocks apart, starting on a negedge.
  task automatic move(input bit cw, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      ph = cw ? cw_of(ph) : ccw_of(ph);
      drive_phase();
      repeat (gap) @(negedge CLK);
    end
  endtask

  initial begin
    reset = 1'b0; monitor = 1'b1; zero = 1'b0; fault_clr = 1'b0;
    ph = 2'b11;
    drive_phase();
    repeat (5) @(negedge CLK);
    check("rst_angle", 32'(angle), 32'd0);
    check("rst_dir",   32'(dir),   32'd1);
    check("rst_step",  32'(step),  32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    reset = 1'b1;
    repeat (20) @(negedge CLK);
    check("prime_angle", 32'(angle),    32'd0);
    check("prime_fault", 32'(fault),    32'd0);
    check("prime_dir",   32'(dir),      32'd1);
    check("prime_steps", 32'(step_cnt), 32'd0);

    // Latency: change before edge N shows up at edge N+5.
    ph = cw_of(ph);
    drive_phase();
    repeat (5) @(posedge CLK);
    #1 check("lat_early_step", 32'(step), 32'd0);
    @(posedge CLK);
    #1 check("lat_step",  32'(step),  32'd1);
    check("lat_angle", 32'(angle), 32'd1);
    repeat (2) @(negedge CLK);

    // Zero on its own.
    zero = 1'b1;
    @(posedge CLK);
    #1 check("zero_angle", 32'(angle), 32'd0);
    @(negedge CLK);
    zero = 1'b0;
    repeat (3) @(negedge CLK);

    // Clockwise sweep through a full revolution.
    base = step_cnt;
    for (int i = 1; i <= 4024; i++) begin
      move(1'b1, 1, 8);
      if (i == 4023) check("cw_top", 32'(angle), 32'd4023);
      if (i == 4024) check("cw_wrap", 32'(angle), 32'd0);
    end
    check("cw_dir",   32'(dir),             32'd1);
    check("cw_steps", 32'(step_cnt - base), 32'd4024);

    // Reverse wrap and a full revolution back.
    move(1'b0, 1, 8);
    check("ccw_wrap", 32'(angle), 32'd4023);
    check("ccw_dir",  32'(dir),   32'd0);
    move(1'b0, 4023, 8);
    check("ccw_zero", 32'(angle), 32'd0);

    // Two-cycle glitch on hall_1 is filtered out.
    base = step_cnt;
    hall_1 = ~ph[1];
    repeat (2) @(negedge CLK);
    hall_1 = ph[1];
    repeat (10) @(negedge CLK);
    check("glitch_steps", 32'(step_cnt - base), 32'd0);
    check("glitch_angle", 32'(angle),           32'd0);

    // Double toggle is illegal; a coincident fault_clr loses to the new fault.
    ph = ~ph;
    drive_phase();
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    fault_clr = 1'b1;
    @(posedge CLK);
    #1 check("fault_set", 32'(fault), 32'd1);
    @(negedge CLK);
    fault_clr = 1'b0;
    repeat (4) @(negedge CLK);
    check("fault_sticky", 32'(fault),           32'd1);
    check("fault_angle",  32'(angle),           32'd0);
    check("fault_steps",  32'(step_cnt - base), 32'd0);
    check("fault_dir",    32'(dir),             32'd0);
    fault_clr = 1'b1;
    @(negedge CLK);
    fault_clr = 1'b0;
    check("fault_clr", 32'(fault), 32'd0);

    // Monitor off holds the angle while steps keep pulsing.
    move(1'b1, 100, 8);
    check("mon_start", 32'(angle), 32'd100);
    monitor = 1'b0;
    base = step_cnt;
    move(1'b1, 10, 8);
    check("mon_hold",  32'(angle),           32'd100);
    check("mon_steps", 32'(step_cnt - base), 32'd10);
    monitor = 1'b1;
    move(1'b1, 1, 8);
    check("mon_resume", 32'(angle), 32'd101);

    // Zero coincident with a step wins.
    ph = cw_of(ph);
    drive_phase();
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    zero = 1'b1;
    @(posedge CLK);
    #1 check("zero_step_pulse", 32'(step),  32'd1);
    check("zero_step_angle", 32'(angle), 32'd0);
    @(negedge CLK);
    zero = 1'b0;
    repeat (4) @(negedge CLK);
    check("zero_step_hold", 32'(angle), 32'd0);

`ifdef QAT_VELOCITY_EN
    base = vv_cnt;
    move(1'b1, 150, 20);
    check("vel_windows", 32'((vv_cnt - base) >= 2), 32'd1);
    check("vel_cw", 32'(last_vel), 32'(16'd50));
    base = vv_cnt;
    move(1'b0, 150, 20);
    check("vel_windows_rev", 32'((vv_cnt - base) >= 2), 32'd1);
    check("vel_ccw", 32'(last_vel), 32'(16'hFFCE));
`else
    check("vel_tied",  32'(velocity), 32'd0);
    check("vv_never",  32'(vv_cnt),   32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/quadrature_angle_tracker.md
# quadrature_angle_tracker

Parametrised, fully synchronous angle tracking unit for the two-channel hall sensor pair on the motor shaft. It synchronises and deglitches `hall_1`/`hall_2`, decodes every quadrature edge as a ±1 step, and maintains a wrapping angle count with configurable counts per revolution. It also derives direction from the sensor phase rather than from an external input, flags illegal transitions, and optionally measures velocity. It sits between the hall sensor pins and the motor control / position readout logic.

## Interface
- `ANGLE_W`, 12, angle counter width; must satisfy 2^ANGLE_W >= COUNTS_PER_REV
- `COUNTS_PER_REV`, 4024, quadrature counts per shaft revolution (angle range 0..COUNTS_PER_REV-1)
- `FILTER_LEN`, 3, consecutive identical samples required before a filtered input changes (>=1)
- `VEL_WINDOW`, 1000, velocity measurement window in CLK cycles
- `VEL_W`, 16, signed velocity output width
- `CLK`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `hall_1`, `hall_2`  in  1  raw asynchronous hall sensor inputs
- `monitor`  in  1  1 = update angle on steps; 0 = hold angle, keep tracking phase
- `zero`  in  1  synchronous clear of angle to 0
- `fault_clr`  in  1  clears sticky `fault`
- `angle`  out  ANGLE_W  current angle count
- `dir`  out  1  last valid step direction (1 = clockwise)
- `step`  out  1  one-cycle pulse per valid decoded step (regardless of `monitor`)
- `fault`  out  1  sticky illegal-transition flag
- `velocity`  out  VEL_W  signed steps per window (only with macro)
- `vel_valid`  out  1  one-cycle pulse when `velocity` updates (only with macro)

## Operation
- Each hall input passes a 2-flop synchroniser, then a per-channel filter: the filtered value takes the synchronised value only after FILTER_LEN consecutive equal samples that differ from the current filtered value.
- Priming: after reset a `primed` flag is 0; the first time both filters are settled, the decoder loads the phase {h1,h2} without generating a step, then sets `primed`.
- Phase sequence clockwise (hall_1 leads): 00→10→11→01→00. Reverse order is anticlockwise.
- Per cycle, compare new vs previous filtered phase: no change → idle; single-bit change in clockwise order → +1, `dir`=1; anticlockwise → −1, `dir`=0; both bits changed → `fault`=1, no step, `dir` unchanged, phase still updated.
- Angle arithmetic modulo COUNTS_PER_REV: +1 at COUNTS_PER_REV−1 → 0; −1 at 0 → COUNTS_PER_REV−1. No other wrap.
- `monitor`=0: `step`/`dir`/`fault` still update, `angle` holds.
- Priority on `angle`: `zero` > step. `zero` with a simultaneous step gives 0.
- `fault_clr` clears `fault`; a fault detected the same cycle wins (fault stays 1).

## Timing
- Reset values: `angle`=0, `dir`=1, `step`=0, `fault`=0, `velocity`=0, `vel_valid`=0, `primed`=0, filters/synchronisers=0.
- Latency: input change stable before rising edge N → `angle`, `dir`, `step` update at edge N+FILTER_LEN+2.
- Input pulses shorter than FILTER_LEN cycles (after sync) are discarded.
- Reset mid-rotation: all state cleared asynchronously; re-priming from the current sensor phase, no spurious step.
- Maximum step rate: one step per FILTER_LEN cycles per channel.

## Configuration
- `QAT_VELOCITY_EN` defined: a VEL_WINDOW-cycle counter accumulates signed steps; on the last window cycle, `velocity` ← accumulator (including that cycle's step), `vel_valid` pulses for one cycle, accumulator restarts at 0. Accumulator saturates at ±(2^(VEL_W−1)−1). Counts steps independent of `monitor`.
- Undefined: no velocity logic; `velocity` tied 0, `vel_valid` tied 0.

## Test plan
- Reset: hold `reset`=0 with hall inputs at 11, release → angle=0, dir=1, fault=0, no `step` during priming.
- Clockwise sweep: 4024 clockwise steps from 0, one per 8 clocks → angle increments to 4023 then reads 0; dir=1; 4024 `step` pulses.
- Reverse wrap: from angle=0, one anticlockwise step → angle=4023, dir=0; 4023 further steps → angle=0.
- Glitch/illegal: 2-cycle pulse on hall_1 → no step, angle unchanged; both inputs toggled same cycle → fault=1, angle unchanged; `fault_clr` → fault=0.
- Monitor/zero: monitor=0 for 10 clockwise steps at angle=100 → angle stays 100, 10 `step` pulses; monitor=1, one step → 101; `zero` coincident with step → 0.
- Velocity (macro defined): 1 clockwise step per 20 clocks, VEL_WINDOW=1000 → velocity=50 with vel_valid every 1000 clocks; reversed → velocity=−50.
